// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_DUTY   = 2'b11
  } mode_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow config, pending flag, period counter and output shaping.
module clk_div_chan
  import clkdiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  mode_e        wr_mode,
  input  logic [W-1:0] wr_div,
  input  logic [W-1:0] wr_high,
  input  logic         en,
  input  logic         sync,
  output logic         pending,
  output logic         out,
  output logic         tick
);

  mode_e        act_mode, sh_mode;
  logic [W-1:0] act_div, act_high, sh_div, sh_high;
  logic [W-1:0] cnt;
  logic         run, tc, apply, out_nxt;

  assign run   = en && (act_mode != MODE_OFF);
  assign tc    = run && !sync && (cnt == act_div - W'(1));
  // A disabled, idle or re-phasing channel has no period to finish, so the
  // shadow can land right away; otherwise wait for the period boundary.
  assign apply = pending && (tc || !run || sync);

  // out lags the counter by one cycle, the same way tick lags TC.
  always_comb begin
    out_nxt = 1'b0;
    case (act_mode)
      MODE_TOGGLE: out_nxt = tc ? ~out : out;
      MODE_PULSE:  out_nxt = tc;
      MODE_DUTY:   out_nxt = (cnt < act_high);
      default:     out_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_mode <= MODE_OFF;
      act_div  <= W'(MIN_DIV);
      act_high <= W'(1);
      sh_mode  <= MODE_OFF;
      sh_div   <= '0;
      sh_high  <= '0;
      pending  <= 1'b0;
      cnt      <= '0;
      out      <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (wr) begin
        sh_mode <= wr_mode;
        sh_div  <= (wr_div < W'(MIN_DIV)) ? W'(MIN_DIV) : wr_div;
        sh_high <= wr_high;
        pending <= 1'b1;
      end
      if (apply) begin
        act_mode <= sh_mode;
        act_div  <= sh_div;
        act_high <= sh_high;
        pending  <= 1'b0;
      end
      if (run && !sync) begin
        cnt  <= tc ? '0 : cnt + W'(1);
        out  <= out_nxt;
        tick <= tc;
      end else begin
        cnt  <= '0;
        out  <= 1'b0;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider with a shared configuration write port.
module prog_clk_div
  import clkdiv_pkg::*;
#(
  parameter int  NCH = 4,
  parameter int  W   = 16,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [1:0]    cfg_mode,
  input  logic [W-1:0]  cfg_div,
  input  logic [W-1:0]  cfg_high,
  input  logic [NCH-1:0] en,
  input  logic          sync,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0] pending, wr;
  logic           in_range, pend_sel;

  always_comb begin
    in_range = (32'(cfg_ch) < NCH);
    pend_sel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) pend_sel = pending[i];
    end
  end

  // Out-of-range channel indices are acknowledged and silently discarded.
  assign cfg_ready = !rst && !(in_range && pend_sel);

  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg_valid && cfg_ready && (cfg_ch == CW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(.W(W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr[g]),
      .wr_mode (mode_e'(cfg_mode)),
      .wr_div  (cfg_div),
      .wr_high (cfg_high),
      .en      (en[g]),
      .sync    (sync),
      .pending (pending[g]),
      .out     (out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: expected out/tick per cycle queued up front, popped each cycle.
module tb_prog_clk_div;
  import clkdiv_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch;
  logic [1:0]     cfg_mode;
  logic [W-1:0]   cfg_div, cfg_high;
  logic [NCH-1:0] en, out, tick;
  logic           sync;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] tick;
  } exp_t;

  exp_t sb[$];
  bit   rq[$];

  always #5 clk = ~clk;

  prog_clk_div #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .en        (en),
    .sync      (sync),
    .out       (out),
    .tick      (tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Program a disabled channel: one cycle to accept, one cycle to apply.
  task automatic cfg_load(input int ch, input mode_e m, input int d, input int h);
    cfg_ch    = CW'(ch);
    cfg_mode  = m;
    cfg_div   = W'(d);
    cfg_high  = W'(h);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; sync = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 0; cfg_mode = MODE_TOGGLE; cfg_div = 3; cfg_high = 0;
    #1;
    n_vec++;
    if (cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready_low: got %b expected 0", cfg_ready);
    end
    step(); step();
    n_vec++;
    if ({out, tick} !== '0) begin
      n_err++; $display("FAIL reset_outputs: out=%b tick=%b expected 0", out, tick);
    end
    rst = 1'b0; cfg_valid = 1'b0;
    #1;
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_write_dropped: ready=%b expected 1", cfg_ready);
    end
    for (int k = 1; k <= 6; k++) sb.push_back('0);
    en = '1;
    for (int k = 1; k <= 6; k++) begin
      exp_t e;
      step();
      e = sb.pop_front();
      n_vec++;
      if ({out, tick} !== e) begin
        n_err++; $display("FAIL reset_off k=%0d: out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.out, e.tick);
      end
    end
    en = '0; step();
  endtask

  task automatic test_toggle();
    en = '0;
    cfg_load(0, MODE_TOGGLE, 3, 0);
    for (int k = 1; k <= 24; k++) begin
      exp_t e;
      e.tick = (k % 3 == 0) ? 4'b0001 : 4'b0000;
      e.out  = (((k / 3) % 2) == 1) ? 4'b0001 : 4'b0000;
      sb.push_back(e);
    end
    en = 4'b0001;
    for (int k = 1; k <= 24; k++) begin
      exp_t e;
      step();
      e = sb.pop_front();
      n_vec++;
      if ({out, tick} !== e) begin
        n_err++; $display("FAIL toggle k=%0d: out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.out, e.tick);
      end
    end
    en = '0; step();
  endtask

  task automatic test_pulse();
    int divs[3]  = '{5, 0, 1};
    int effs[3]  = '{5, 2, 2};
    int lens[3]  = '{20, 8, 8};
    for (int t = 0; t < 3; t++) begin
      en = '0;
      cfg_load(1, MODE_PULSE, divs[t], 0);
      for (int k = 1; k <= lens[t]; k++) begin
        exp_t e;
        e.tick = (k % effs[t] == 0) ? 4'b0010 : 4'b0000;
        e.out  = e.tick;
        sb.push_back(e);
      end
      en = 4'b0010;
      for (int k = 1; k <= lens[t]; k++) begin
        exp_t e;
        step();
        e = sb.pop_front();
        n_vec++;
        if ({out, tick} !== e) begin
          n_err++; $display("FAIL pulse div=%0d k=%0d: out=%b tick=%b expected out=%b tick=%b", divs[t], k, out, tick, e.out, e.tick);
        end
      end
    end
    en = '0; step();
  endtask

  task automatic test_duty();
    int highs[3] = '{3, 0, 12};
    for (int t = 0; t < 3; t++) begin
      en = '0;
      cfg_load(2, MODE_DUTY, 10, highs[t]);
      for (int k = 1; k <= 30; k++) begin
        exp_t e;
        e.tick = (k % 10 == 0) ? 4'b0100 : 4'b0000;
        e.out  = (((k - 1) % 10) < highs[t]) ? 4'b0100 : 4'b0000;
        sb.push_back(e);
      end
      en = 4'b0100;
      for (int k = 1; k <= 30; k++) begin
        exp_t e;
        step();
        e = sb.pop_front();
        n_vec++;
        if ({out, tick} !== e) begin
          n_err++; $display("FAIL duty high=%0d k=%0d: out=%b tick=%b expected out=%b tick=%b", highs[t], k, out, tick, e.out, e.tick);
        end
      end
    end
    en = '0; step();
  endtask

  // div 4 -> write div 8 mid-period (lands at next TC), then a write in the TC cycle lands one TC later.
  task automatic test_reconfig();
    en = '0;
    cfg_load(0, MODE_PULSE, 4, 0);
    for (int k = 1; k <= 32; k++) begin
      exp_t e;
      bit   tk;
      if (k <= 8)       tk = (k % 4 == 0);
      else if (k <= 24) tk = ((k - 8) % 8 == 0);
      else              tk = ((k - 24) % 3 == 0);
      e.tick = tk ? 4'b0001 : 4'b0000;
      e.out  = e.tick;
      sb.push_back(e);
      rq.push_back(!(((k - 1) >= 6 && (k - 1) <= 7) || ((k - 1) >= 16 && (k - 1) <= 23)));
    end
    en = 4'b0001;
    for (int k = 1; k <= 32; k++) begin
      exp_t e;
      bit   r;
      cfg_ch    = 0;
      cfg_mode  = MODE_PULSE;
      cfg_div   = (k == 6) ? W'(8) : W'(3);
      cfg_high  = 0;
      cfg_valid = (k == 6 || k == 16);
      #1;
      r = rq.pop_front();
      n_vec++;
      if (cfg_ready !== r) begin
        n_err++; $display("FAIL reconfig_ready k=%0d: got %b expected %b", k, cfg_ready, r);
      end
      step();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({out, tick} !== e) begin
        n_err++; $display("FAIL reconfig k=%0d: out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.out, e.tick);
      end
    end
    en = '0; step();
  endtask

  task automatic test_sync();
    en = '0;
    cfg_load(0, MODE_PULSE, 3, 0);
    cfg_load(1, MODE_PULSE, 7, 0);
    sb.push_back('0);
    sb.push_back('0);
    sb.push_back('0);
    for (int m = 1; m <= 42; m++) begin
      exp_t e;
      e.tick = {2'b00, (m % 7 == 0), (m % 3 == 0)};
      e.out  = e.tick;
      sb.push_back(e);
    end
    en = 4'b0001;
    for (int k = 1; k <= 45; k++) begin
      exp_t e;
      // ch0 sits in its TC when sync arrives; that TC must not tick
      if (k == 3) begin
        sync = 1'b1;
        en   = 4'b0011;
      end
      step();
      sync = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({out, tick} !== e) begin
        n_err++; $display("FAIL sync k=%0d: out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.out, e.tick);
      end
    end
    en = '0; step();
  endtask

  task automatic test_reset_mid();
    en = '0;
    cfg_load(0, MODE_TOGGLE, 4, 0);
    for (int k = 1; k <= 6; k++) begin
      exp_t e;
      e.tick = (k % 4 == 0) ? 4'b0001 : 4'b0000;
      e.out  = (((k / 4) % 2) == 1) ? 4'b0001 : 4'b0000;
      sb.push_back(e);
    end
    en = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      exp_t e;
      if (k == 6) begin
        cfg_ch = 0; cfg_mode = MODE_TOGGLE; cfg_div = 8; cfg_high = 0;
        cfg_valid = 1'b1;
      end
      step();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({out, tick} !== e) begin
        n_err++; $display("FAIL rstmid_run k=%0d: out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.out, e.tick);
      end
    end
    cfg_ch = 0;
    #1;
    n_vec++;
    if (cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pending: ready=%b expected 0", cfg_ready);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if ({out, tick} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: out=%b tick=%b expected 0", out, tick);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pending_cleared: ready=%b expected 1", cfg_ready);
    end
    for (int k = 1; k <= 10; k++) sb.push_back('0);
    en = '1;
    for (int k = 1; k <= 10; k++) begin
      exp_t e;
      step();
      e = sb.pop_front();
      n_vec++;
      if ({out, tick} !== e) begin
        n_err++; $display("FAIL rstmid_off k=%0d: out=%b tick=%b expected out=%b tick=%b", k, out, tick, e.out, e.tick);
      end
    end
    en = '0; step();
  endtask

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_div = '0; cfg_high = '0;
    test_reset();
    test_toggle();
    test_pulse();
    test_duty();
    test_reconfig();
    test_sync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter W, default 16, counter/divisor width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration write request.
REQ-006 SHALL have port cfg_ready  output  1  configuration write can be accepted.
REQ-007 SHALL have port cfg_ch  input  $clog2(NCH) (min 1)  target channel index.
REQ-008 SHALL have port cfg_mode  input  2  mode: 00 OFF, 01 TOGGLE, 10 PULSE, 11 DUTY.
REQ-009 SHALL have port cfg_div  input  W  period in clk cycles.
REQ-010 SHALL have port cfg_high  input  W  high time in cycles (DUTY mode only).
REQ-011 SHALL have port en  input  NCH  per-channel run enable.
REQ-012 SHALL have port sync  input  1  phase-restart of all channels.
REQ-013 SHALL have port out  output  NCH  registered divided outputs.
REQ-014 SHALL have port tick  output  NCH  registered one-cycle terminal-count strobes.

Function
REQ-015 SHALL accept a write when cfg_valid && cfg_ready; accepted values go to a per-channel shadow register and set that channel's pending flag.
REQ-016 SHALL drive cfg_ready = !pending[cfg_ch] && !rst, combinationally; an out-of-range cfg_ch SHALL be ignored with cfg_ready high.
REQ-017 SHALL clamp the effective divisor to max(cfg_div, 2).
REQ-018 SHALL run each active channel counter cnt from 0 to div-1 and wrap to 0; terminal count (TC) is the cycle in which cnt == div-1 and en is high.
REQ-019 SHALL apply a pending shadow at the channel's next TC. If the channel is disabled, mode is OFF, or sync is high, the shadow SHALL be applied in the next cycle. Applying clears pending and resets cnt to 0.
REQ-020 SHALL store a write accepted in a channel's TC cycle in the shadow; that TC SHALL NOT apply it; it is applied at the following TC.
REQ-021 TOGGLE: out inverts on the cycle after each TC, giving a 2*div-cycle period with 50% duty.
REQ-022 PULSE: out is high for exactly the one cycle after each TC, giving a period of div cycles.
REQ-023 DUTY: out is registered (cnt < high); high == 0 gives constant 0, and high >= div gives constant 1.
REQ-024 OFF: cnt is held at 0, out is 0, and tick is 0.
REQ-025 SHALL assert tick[c] for exactly the one cycle after each TC, in every mode except OFF.
REQ-026 With en[c] low: cnt[c] is held at 0, out[c] is 0 from the next cycle, and tick[c] is 0; on re-enable, counting starts at 0.
REQ-027 sync high: all cnt are set to 0 and all out to 0 in the next cycle; TC and tick are suppressed in that cycle; sync takes priority over TC.
REQ-028 Mode and divisor changes SHALL take effect only at a TC boundary, so out never has a high or low phase shorter than min(old, new) programmed phase.

Reset
REQ-029 On rst: every channel's active mode is OFF, div = 2, high = 1; shadows and pending are 0; out and tick are 0.
REQ-030 A write presented during rst SHALL be dropped.
REQ-031 rst asserted mid-operation SHALL discard pending shadows and return all outputs to 0 on the next edge.

Structure
REQ-032 Package clkdiv_pkg SHALL hold the mode enum (OFF, TOGGLE, PULSE, DUTY) and the constant MIN_DIV = 2.
REQ-033 Sub-module clk_div_chan SHALL implement one channel (shadow, pending, counter, output logic).
REQ-034 Top level SHALL instantiate NCH clk_div_chan instances and decode the write handshake.
REQ-035 Target size: 150-300 RTL lines in total.

Verification
REQ-036 Reset, then write ch0 TOGGLE div=3 with en=1 -> out[0] has a 6-cycle period at 50% duty; tick[0] fires every 3 cycles.
REQ-037 ch1 PULSE div=5 -> out[1] is one cycle high every 5 cycles, coincident with tick[1]; cfg_div=0 or 1 behaves as div=2.
REQ-038 ch2 DUTY div=10 high=3 -> 3 high / 7 low; high=0 gives constant 0; high=12 gives constant 1.
REQ-039 While ch0 runs div=4, write div=8 mid-period -> cfg_ready is low for ch0 until its TC, the old period completes, and the next period is 8; a write in the TC cycle applies one TC later.
REQ-040 Channels at div 3 and 7, sync pulsed -> both restart at cnt=0 and tick in the same cycle every 21 cycles; a TC coinciding with sync gives no tick.
REQ-041 rst asserted mid-count with a pending write -> all out and tick are 0 next edge; pending is cleared and the mode is OFF after release.
